// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
// register_file_sb : 2-read / 2-write register file with async reset, optional
//                    hardwired-zero R0, write bypass and pending-write scoreboard
// Revision        : 1.0
// ============================================================================
module register_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic              rd_a_busy,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_b_busy,
  input  logic              wr_a_en,
  input  logic [ADDR_W-1:0] wr_a_addr,
  input  logic [DATA_W-1:0] wr_a_data,
  input  logic              wr_b_en,
  input  logic [ADDR_W-1:0] wr_b_addr,
  input  logic [DATA_W-1:0] wr_b_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_hit_a;
  logic [DEPTH-1:0]  w_hit_b;
  logic [DEPTH-1:0]  w_hit_lock;

  // One-hot decode of every write and lock request; R0 is masked out when tied off
  always_comb begin
    w_hit_a    = '0;
    w_hit_b    = '0;
    w_hit_lock = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit_a[i]    = wr_a_en && (wr_a_addr == ADDR_W'(i));
      w_hit_b[i]    = wr_b_en && (wr_b_addr == ADDR_W'(i));
      w_hit_lock[i] = lock_en && (lock_addr == ADDR_W'(i));
    end
    if (ZERO_REG != 0) begin
      w_hit_a[0]    = 1'b0;
      w_hit_b[0]    = 1'b0;
      w_hit_lock[0] = 1'b0;
    end
  end

  // Port B has priority on a shared address; a lock outranks a same-cycle clearing write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit_b[i]) begin
          r_mem[i] <= wr_b_data;
        end else if (w_hit_a[i]) begin
          r_mem[i] <= wr_a_data;
        end
        if (w_hit_lock[i]) begin
          r_pending[i] <= 1'b1;
        end else if (w_hit_a[i] || w_hit_b[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  assign any_busy = |r_pending;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;
    logic              w_zero;

    assign w_addr = (p == 0) ? rd_a_addr : rd_b_addr;
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

    // Reset gating keeps a forwarded write from leaking out while rst_n is low
    always_comb begin
      w_data = r_mem[w_addr];
      if (BYPASS != 0) begin
        if (wr_b_en && (wr_b_addr == w_addr)) begin
          w_data = wr_b_data;
        end else if (wr_a_en && (wr_a_addr == w_addr)) begin
          w_data = wr_a_data;
        end
      end
      if (w_zero || !rst_n) begin
        w_data = '0;
      end
    end

    assign w_busy = r_pending[w_addr] && !w_zero;
  end

  assign rd_a_data = g_rd[0].w_data;
  assign rd_a_busy = g_rd[0].w_busy;
  assign rd_b_data = g_rd[1].w_data;
  assign rd_b_busy = g_rd[1].w_busy;

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// tb_register_file_sb : directed vector table plus reset/scoreboard sequences,
// run on a bypass/no-R0 instance and a no-bypass/R0-tied instance side by side.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_a_addr, rd_b_addr, wr_a_addr, wr_b_addr, lock_addr;
  logic [15:0] wr_a_data, wr_b_data;
  logic        wr_a_en, wr_b_en, lock_en;

  logic [15:0] d_a_data, d_b_data, z_a_data, z_b_data;
  logic        d_a_busy, d_b_busy, d_any, z_a_busy, z_b_busy, z_any;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_a_addr(rd_a_addr), .rd_a_data(d_a_data), .rd_a_busy(d_a_busy),
    .rd_b_addr(rd_b_addr), .rd_b_data(d_b_data), .rd_b_busy(d_b_busy),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
    .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data),
    .lock_en(lock_en), .lock_addr(lock_addr), .any_busy(d_any)
  );

  register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_dz (
    .clk(clk), .rst_n(rst_n),
    .rd_a_addr(rd_a_addr), .rd_a_data(z_a_data), .rd_a_busy(z_a_busy),
    .rd_b_addr(rd_b_addr), .rd_b_data(z_b_data), .rd_b_busy(z_b_busy),
    .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
    .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data),
    .lock_en(lock_en), .lock_addr(lock_addr), .any_busy(z_any)
  );

  typedef struct {
    logic        wa_en; logic [3:0] wa_addr; logic [15:0] wa_data;
    logic        wb_en; logic [3:0] wb_addr; logic [15:0] wb_data;
    logic        lk_en; logic [3:0] lk_addr;
    logic [3:0]  ra;    logic [3:0] rb;
    logic [15:0] e_a;   logic e_ab; logic [15:0] e_b; logic e_bb; logic e_any;
    logic [15:0] z_a;   logic z_ab; logic [15:0] z_b; logic z_any;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wae, input logic [3:0] waa, input logic [15:0] wad,
                       input logic wbe, input logic [3:0] wba, input logic [15:0] wbd,
                       input logic lke, input logic [3:0] lka,
                       input logic [3:0] ra, input logic [3:0] rb);
    wr_a_en = wae; wr_a_addr = waa; wr_a_data = wad;
    wr_b_en = wbe; wr_b_addr = wba; wr_b_data = wbd;
    lock_en = lke; lock_addr = lka;
    rd_a_addr = ra; rd_b_addr = rb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             wa_en wa  wa_data   wb_en wb  wb_data   lk  la  ra  rb   e_a      ab  e_b      bb  any  z_a      ab  z_b      zany
    vecs[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd15, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 4'd3, 16'h1234, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd4,  16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3,  16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
    vecs[3]  = '{1'b1, 4'd5, 16'h00AA, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd3,  16'h00AA, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd5,  16'h0000, 1'b0, 16'h00AA, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00AA, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 4'd7, 4'd7,  16'h1111, 1'b1, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[6]  = '{1'b1, 4'd7, 16'h0042, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd3,  16'h0042, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h1111, 1'b1, 16'hBEEF, 1'b1};
    vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd7,  16'h0042, 1'b0, 16'h0042, 1'b0, 1'b0, 16'h0042, 1'b0, 16'h0042, 1'b0};
    vecs[8]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd0, 4'd0,  16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd1,  16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 4'd2, 16'h2222, 1'b1, 4'd0, 16'h0001, 1'b0, 4'd0, 4'd2, 4'd0,  16'h2222, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd2,  16'h0001, 1'b0, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h2222, 1'b0};
    vecs[12] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 16'hABCD, 1'b0, 4'd0, 4'd15, 4'd14, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd15, 4'd5, 16'hABCD, 1'b0, 16'h00AA, 1'b0, 1'b0, 16'hABCD, 1'b0, 16'h00AA, 1'b0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scatter random writes and locks so reset has something to clear
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, 4'($urandom_range(15)), 16'($urandom), 1'b1, 4'($urandom_range(15)),
            16'($urandom), 1'b1, 4'($urandom_range(15)), 4'd0, 4'd0);
    end
    #2 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, 4'(i), 16'($urandom) | 16'h0001, 1'b1, 4'(15 - i), 16'($urandom) | 16'h0001,
            1'b1, 4'(i), 4'(i), 4'(15 - i));
      #1;
      check($sformatf("rst_d_a_data[%0d]", i), d_a_data, 16'h0000);
      check($sformatf("rst_d_b_data[%0d]", i), d_b_data, 16'h0000);
      check($sformatf("rst_z_a_data[%0d]", i), z_a_data, 16'h0000);
      check($sformatf("rst_busy[%0d]", i), {12'h0, d_a_busy, d_b_busy, z_a_busy, z_b_busy}, 16'h0000);
      check($sformatf("rst_any[%0d]", i), {14'h0, d_any, z_any}, 16'h0000);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].wa_en, vecs[i].wa_addr, vecs[i].wa_data, vecs[i].wb_en, vecs[i].wb_addr,
            vecs[i].wb_data, vecs[i].lk_en, vecs[i].lk_addr, vecs[i].ra, vecs[i].rb);
      #1;
      check($sformatf("v%0d_d_a_data", i), d_a_data, vecs[i].e_a);
      check($sformatf("v%0d_d_a_busy", i), {15'h0, d_a_busy}, {15'h0, vecs[i].e_ab});
      check($sformatf("v%0d_d_b_data", i), d_b_data, vecs[i].e_b);
      check($sformatf("v%0d_d_b_busy", i), {15'h0, d_b_busy}, {15'h0, vecs[i].e_bb});
      check($sformatf("v%0d_d_any", i), {15'h0, d_any}, {15'h0, vecs[i].e_any});
      check($sformatf("v%0d_z_a_data", i), z_a_data, vecs[i].z_a);
      check($sformatf("v%0d_z_a_busy", i), {15'h0, z_a_busy}, {15'h0, vecs[i].z_ab});
      check($sformatf("v%0d_z_b_data", i), z_b_data, vecs[i].z_b);
      check($sformatf("v%0d_z_any", i), {15'h0, z_any}, {15'h0, vecs[i].z_any});
    end

    // Lock 9 (with a same-cycle write), then an asynchronous reset pulse mid-cycle
    @(negedge clk);
    drive(0, 0, 0, 1'b1, 4'd9, 16'h5555, 1'b1, 4'd9, 4'd9, 4'd9);
    #1;
    check("lk9_d_bypass", d_a_data, 16'h5555);
    check("lk9_z_nobypass", z_a_data, 16'h0000);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'd9, 4'd3);
    #1;
    check("lk9_d_busy", {15'h0, d_a_busy}, 16'h0001);
    check("lk9_d_any", {15'h0, d_any}, 16'h0001);
    check("lk9_d_data", d_a_data, 16'h5555);
    check("lk9_z_busy", {15'h0, z_a_busy}, 16'h0001);
    check("lk9_z_data", z_a_data, 16'h5555);
    #2 rst_n = 1'b0;
    drive(1'b1, 4'd9, 16'h7777, 0, 0, 0, 0, 0, 4'd9, 4'd3);
    #1;
    check("rst9_busy", {14'h0, d_a_busy, z_a_busy}, 16'h0000);
    check("rst9_any", {14'h0, d_any, z_any}, 16'h0000);
    check("rst9_d_data", d_a_data, 16'h0000);
    check("rst9_z_data", z_a_data, 16'h0000);
    check("rst9_z_reg3", z_b_data, 16'h0000);
    @(posedge clk);
    #1;
    check("rst9_inflight_d", d_a_data, 16'h0000);
    check("rst9_inflight_z", z_a_data, 16'h0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_d_data", d_a_data, 16'h7777);
    check("post_rst_z_data", z_a_data, 16'h7777);
    check("post_rst_busy", {14'h0, d_a_busy, z_a_busy}, 16'h0000);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
